// File: rtl/mat_mul_arbiter.sv
// Round-robin front end that shares one mat_mul between R requesters.
// One operation in flight; results return tagged with the requester ID, or as an error on watchdog expiry.
module mat_mul_arbiter #(
    parameter int unsigned W_IN    = 8,
    parameter int unsigned W_OUT   = 32,
    parameter int unsigned N       = 8,
    parameter int unsigned R       = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [R-1:0]          req_valid,
    output logic [R-1:0]          req_ready,
    input  logic [R*N*N*W_IN-1:0] req_matrix_1,
    input  logic [R*N*N*W_IN-1:0] req_matrix_2,
    output logic                  mm_resetn,
    output logic                  mm_valid_in,
    output logic [N*N*W_IN-1:0]   mm_matrix_1,
    output logic [N*N*W_IN-1:0]   mm_matrix_2,
    input  logic                  mm_valid_out,
    input  logic [N*N*W_OUT-1:0]  mm_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [N*N*W_OUT-1:0]  resp_result,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int unsigned A_W   = N * N * W_IN;
    localparam int unsigned RES_W = N * N * W_OUT;
    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mm_valid_in_d;
    logic [A_W-1:0]    mm_matrix_1_d, mm_matrix_2_d;
    logic              resp_valid_d, resp_err_d;
    logic [ID_W-1:0]   resp_id_d;
    logic [RES_W-1:0]  resp_result_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;

    assign mm_resetn = ~reset;
    assign busy      = (state_q != S_IDLE);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= int'(R); k++) begin
            cand = (int'(rr_ptr_q) + k) % int'(R);
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        mm_valid_in_d = 1'b0;
        mm_matrix_1_d = mm_matrix_1;
        mm_matrix_2_d = mm_matrix_2;
        resp_valid_d  = resp_valid;
        resp_err_d    = resp_err;
        resp_id_d     = resp_id;
        resp_result_d = resp_result;
        req_ready     = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    mm_matrix_1_d        = req_matrix_1[grant_idx*A_W +: A_W];
                    mm_matrix_2_d        = req_matrix_2[grant_idx*A_W +: A_W];
                    rr_ptr_d             = grant_idx;
                    resp_id_d            = grant_idx;
                    mm_valid_in_d        = 1'b1;
                    state_d              = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins over the error.
                if (mm_valid_out) begin
                    resp_result_d = mm_result;
                    resp_err_d    = 1'b0;
                    resp_valid_d  = 1'b1;
                    state_d       = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    resp_result_d = '0;
                    resp_err_d    = 1'b1;
                    resp_valid_d  = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= ID_W'(R - 1);
            cnt_q       <= '0;
            mm_valid_in <= 1'b0;
            mm_matrix_1 <= '0;
            mm_matrix_2 <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            mm_valid_in <= mm_valid_in_d;
            mm_matrix_1 <= mm_matrix_1_d;
            mm_matrix_2 <= mm_matrix_2_d;
            resp_valid  <= resp_valid_d;
            resp_err    <= resp_err_d;
            resp_id     <= resp_id_d;
            resp_result <= resp_result_d;
        end
    end

endmodule

// File: tb/tb_mat_mul_arbiter.sv
// Bench for mat_mul_arbiter: mat_mul stub, transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_mat_mul_arbiter;

    localparam int W_IN  = 8;
    localparam int W_OUT = 32;
    localparam int N     = 2;
    localparam int R     = 4;
    localparam int ID_W  = 2;
    localparam int TO    = 15;
    localparam int AW    = N * N * W_IN;
    localparam int RW    = N * N * W_OUT;

    logic            clk = 1'b0;
    logic            reset;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*AW-1:0] req_matrix_1, req_matrix_2;
    logic            mm_resetn, mm_valid_in;
    logic [AW-1:0]   mm_matrix_1, mm_matrix_2;
    logic            mm_valid_out = 1'b0;
    logic [RW-1:0]   mm_result;
    logic            resp_valid, resp_ready, resp_err, busy;
    logic [ID_W-1:0] resp_id;
    logic [RW-1:0]   resp_result;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mat_mul_arbiter #(
        .W_IN(W_IN), .W_OUT(W_OUT), .N(N), .R(R), .ID_W(ID_W), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_matrix_1(req_matrix_1), .req_matrix_2(req_matrix_2),
        .mm_resetn(mm_resetn), .mm_valid_in(mm_valid_in),
        .mm_matrix_1(mm_matrix_1), .mm_matrix_2(mm_matrix_2),
        .mm_valid_out(mm_valid_out), .mm_result(mm_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Signed N x N product; element (i,j) sits at flat index i*N+j.
    function automatic logic [RW-1:0] matmul(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [RW-1:0] r;
        int acc;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += $signed(a[(i*N+k)*W_IN +: W_IN]) * $signed(b[(k*N+j)*W_IN +: W_IN]);
                r[(i*N+j)*W_OUT +: W_OUT] = W_OUT'(acc);
            end
        return r;
    endfunction

    function automatic int rr_pick(input logic [R-1:0] v, input int last);
        for (int k = 1; k <= R; k++)
            if (v[(last + k) % R]) return (last + k) % R;
        return -1;
    endfunction

    // mat_mul stub: fixed latency from the start pulse, optional hang and stray pulse.
    int            stub_lat   = 5;
    bit            stub_never = 1'b0;
    int            stray_at   = -1;
    int            fire       = -1;
    logic [RW-1:0] stub_data  = '0;
    assign mm_result = stub_data;

    always @(posedge clk) begin
        if (!mm_resetn) begin
            fire         <= -1;
            mm_valid_out <= 1'b0;
        end else begin
            if (mm_valid_in) begin
                fire      <= cyc + stub_lat;
                stub_data <= matmul(mm_matrix_1, mm_matrix_2);
            end
            mm_valid_out <= (!stub_never && fire == cyc + 1) || (stray_at == cyc + 1);
        end
    end

    // Reference model: one transaction timeline, checked on every cycle.
    bit              m_busy = 1'b0;
    int              m_ptr = R - 1;
    int              m_t = 0;
    int              m_resp_at = -1;
    logic [ID_W-1:0] m_id = '0;
    logic [AW-1:0]   m_a, m_b;
    logic [RW-1:0]   m_res;
    bit              m_err;
    int              g;
    logic [R-1:0]    exp_rdy;
    bit              exp_mvi, exp_rv;

    always @(negedge clk) begin
        if (reset) begin
            check("mm_resetn_in_reset", mm_resetn, 0);
            m_busy = 1'b0;
            m_ptr  = R - 1;
        end else begin
            check("mm_resetn", mm_resetn, 1);
            check("busy", busy, m_busy);
            g = m_busy ? -1 : rr_pick(req_valid, m_ptr);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            exp_mvi = m_busy && (cyc == m_t + 1);
            check("mm_valid_in", mm_valid_in, exp_mvi);
            if (exp_mvi) begin
                check("mm_matrix_1", mm_matrix_1, m_a);
                check("mm_matrix_2", mm_matrix_2, m_b);
            end
            exp_rv = m_busy && m_resp_at >= 0 && cyc >= m_resp_at;
            check("resp_valid", resp_valid, exp_rv);
            if (exp_rv) begin
                check("resp_id", resp_id, m_id);
                check("resp_result", resp_result, m_res);
                check("resp_err", resp_err, m_err);
            end else begin
                check("resp_err_idle", resp_err, 0);
            end
            if (exp_rv && resp_ready) begin
                m_busy = 1'b0;
            end else if (m_busy && m_resp_at < 0 && cyc >= m_t + 2) begin
                if (mm_valid_out) begin
                    m_resp_at = cyc + 1;
                    m_res     = matmul(m_a, m_b);
                    m_err     = 1'b0;
                end else if (cyc == m_t + 2 + TO) begin
                    m_resp_at = cyc + 1;
                    m_res     = '0;
                    m_err     = 1'b1;
                end
            end
            if (g >= 0) begin
                m_busy    = 1'b1;
                m_t       = cyc;
                m_id      = ID_W'(g);
                m_ptr     = g;
                m_a       = req_matrix_1[g*AW +: AW];
                m_b       = req_matrix_2[g*AW +: AW];
                m_resp_at = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        check("resp_wait_bound", resp_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_wait_bound", busy, 0);
    endtask

    task automatic set_ops(input int r, input logic [AW-1:0] a, input logic [AW-1:0] b);
        req_matrix_1[r*AW +: AW] = a;
        req_matrix_2[r*AW +: AW] = b;
    endtask

    logic [R-1:0] got_g [5];
    logic [R-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int n, ng;
        reset        = 1'b1;
        req_valid    = '0;
        req_matrix_1 = '0;
        req_matrix_2 = '0;
        resp_ready   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: requester 2, A = identity, B = all 2s, latency 5
        set_ops(2, 32'h01000001, 32'h02020202);
        req_valid = 4'b0100;
        #1 check("t1_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("t1_mm_valid_in", mm_valid_in, 1);
        wait_resp(n);
        check("t1_latency", n, 6);
        check("t1_resp_id", resp_id, 2);
        check("t1_resp_result", resp_result, {32'd2, 32'd2, 32'd2, 32'd2});
        check("t1_resp_err", resp_err, 0);
        wait_idle();

        // 2: all requesters valid, grants rotate from requester 0
        do_reset();
        stub_lat  = 2;
        set_ops(0, 32'h01020304, 32'h05060708);
        set_ops(1, 32'h11111111, 32'h22222222);
        set_ops(3, 32'hFF01FF01, 32'h7F80017F);
        req_valid = 4'b1111;
        ng = 0;
        for (int b = 0; b < 200 && ng < 5; b++) begin
            #1;
            if (req_ready != '0) begin
                got_g[ng] = req_ready;
                ng++;
            end
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) check($sformatf("t2_grant%0d", i), got_g[i], exp_g[i]);
        wait_idle();

        // 3: response back-pressure for 5 cycles
        stub_lat   = 3;
        resp_ready = 1'b0;
        set_ops(1, 32'hFC0302FF, 32'h08070605);
        req_valid = 4'b0010;
        #1 check("t3_req_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1111;
        wait_resp(n);
        check("t3_resp_id", resp_id, 1);
        check("t3_resp_result", resp_result, {32'hFFFFFFF2, 32'hFFFFFFF3, 32'd10, 32'd9});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", resp_valid, 1);
            check("t3_hold_busy", busy, 1);
            check("t3_hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        check("t3_idle_busy", busy, 0);
        check("t3_idle_resp_valid", resp_valid, 0);
        check("t3_next_grant", req_ready, 4'b0100);
        req_valid = '0;
        tick();

        // 4: mat_mul never answers, watchdog returns an error
        stub_never = 1'b1;
        set_ops(3, 32'h01010101, 32'h01010101);
        req_valid = 4'b1000;
        #1 check("t4_req_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        wait_resp(n);
        check("t4_latency", n, 17);
        check("t4_resp_id", resp_id, 3);
        check("t4_resp_err", resp_err, 1);
        check("t4_resp_result", resp_result, 0);
        wait_idle();
        stub_never = 1'b0;
        stub_lat   = 4;
        set_ops(0, 32'h01000001, 32'h04030201);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        wait_resp(n);
        check("t4b_resp_id", resp_id, 0);
        check("t4b_resp_err", resp_err, 0);
        check("t4b_resp_result", resp_result, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_idle();

        // 5: result arrives exactly on the timeout cycle
        stub_lat = 16;
        set_ops(1, 32'h01010101, 32'hFE000003);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_resp(n);
        check("t5_latency", n, 17);
        check("t5_resp_err", resp_err, 0);
        check("t5_resp_result", resp_result, {32'hFFFFFFFE, 32'd3, 32'hFFFFFFFE, 32'd3});
        wait_idle();

        // 6: reset mid-WAIT, stray mm_valid_out in IDLE, then fresh priority
        stub_lat = 10;
        set_ops(2, 32'h05050505, 32'h03030303);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1 check("t6_mm_resetn_low", mm_resetn, 0);
        tick();
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_resp_valid", resp_valid, 0);
        check("t6_mm_valid_in", mm_valid_in, 0);
        check("t6_resp_id", resp_id, 0);
        check("t6_resp_result", resp_result, 0);
        check("t6_resp_err", resp_err, 0);
        check("t6_mm_matrix_1", mm_matrix_1, 0);
        check("t6_mm_matrix_2", mm_matrix_2, 0);
        stray_at = cyc + 2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_stray_resp_valid", resp_valid, 0);
            check("t6_stray_busy", busy, 0);
        end
        stub_lat  = 3;
        req_valid = 4'b1111;
        #1 check("t6_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp(n);
        check("t6_resp_id_after", resp_id, 0);
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
